instr_fetch_seq: RTL and testbench
==================================

// Module: instr_fetch_seq
// PURPOSE
//  Fetch/PC sequencer feeding the 4-bit opcode decoder of the SCU datapath.
//  - Holds the PC and requests instruction words from instruction memory.
//  - Splits each word into opcode/rd/rs/rt and presents it downstream.
//  - Takes back the decoder's jump/jumpMem/branchZ/branchN outcome and selects the next PC.
// PARAMETERS
//  PC_W      8     PC / instruction-memory address width
//  RESET_PC  0     PC value loaded at reset
// PORTS
//  clk          in   1     single clock, rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  imem_req     out  1     fetch request; held high until imem_ready
//  imem_addr    out  PC_W  fetch address (= pc); stable while imem_req
//  imem_ready   in   1     memory accepted the request; imem_rdata valid this cycle
//  imem_rdata   in   32    instruction word
//  instr_valid  out  1     issued instruction valid
//  instr_accept in   1     downstream takes the issued instruction
//  instr        out  32    registered instruction word
//  opcode       out  4     instr[31:28]
//  rd/rs/rt     out  6 ea  instr[27:22] / [21:16] / [15:10]
//  pc_out       out  PC_W  PC of issued instruction (Save PC operand)
//  ctl_valid    in   1     decoder/ALU outcome valid for the issued instruction
//  jump,jumpMem,branchZ,branchN in 1 ea  decoder control for that instruction
//  flag_z,flag_n in  1 ea  ALU zero/negative flags qualifying branches
//  target_addr  in   PC_W  redirect target (register or memory value)
//  illegal_op   out  1     sticky undefined-opcode flag (FETCH_BADOP_EN only)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0,
//   instr=0, pc_out=0, illegal_op=0. Any in-flight request is abandoned.
//  FSM:
//   IDLE    -> FETCH unconditionally, next cycle.
//   FETCH   imem_req=1, imem_addr=pc.
//           If imem_ready: capture imem_rdata into instr, pc_out<=pc, -> ISSUE.
//           imem_ready in the same cycle as first imem_req is legal.
//   ISSUE   instr_valid=1; instr/fields held stable.
//           On instr_accept: instr_valid drops next cycle, -> RESOLVE.
//   RESOLVE Waits for ctl_valid. ctl_valid is ignored in every other state.
//           take = jump | jumpMem | (branchZ & flag_z) | (branchN & flag_n).
//           Next pc = take ? target_addr : pc+1, -> FETCH.
//  Arithmetic and timing:
//   - pc+1 wraps modulo 2^PC_W (all-ones -> 0); no overflow flag.
//   - Minimum 3 cycles per instruction (FETCH, ISSUE, RESOLVE), with ready,
//     accept and ctl_valid each asserted on the first cycle offered.
//   - opcode/rd/rs/rt are continuous slices of the registered instr; no combinational path from imem_rdata.
//  Boundary conditions:
//   - Simultaneous jump and branch: any true term redirects; target_addr is the single target.
//   - Opcode 0000 (NOP) sequences like any other instruction; its decoder outcome is pc+1.
//   - A late imem_ready after reset mid-FETCH is ignored (imem_req is 0 in IDLE).
// CONFIGURATION
//  FETCH_BADOP_EN defined:
//   - In ISSUE, an opcode in {0001,0010,1001,1100,1101} sets illegal_op (sticky until reset).
//   - Such an instruction is not presented: instr_valid stays 0, -> HALT.
//   - HALT is exited only by reset; no further imem_req.
//  FETCH_BADOP_EN undefined:
//   - illegal_op tied 0; no HALT state; every opcode is issued.
// TESTING
//  1 reset, RESET_PC=0, ready/accept/ctl_valid always 1, no redirect
//    -> imem_addr 0,1,2 on every 3rd cycle; instr_valid pulses 1 cycle each.
//  2 imem_ready held low 4 cycles in FETCH at pc=5
//    -> imem_req high, imem_addr=5 stable throughout; ISSUE on cycle ready rises.
//  3 branchZ=1 with flag_z=1, target_addr=8'h40 -> next imem_addr=8'h40.
//    Same with flag_z=0 -> pc+1.
//  4 pc=8'hFF, no redirect -> next imem_addr=8'h00.
//  5 rst_n low mid-FETCH while imem_ready=1
//    -> imem_req=0 and pc=RESET_PC immediately (async); no instr_valid.
//  6 FETCH_BADOP_EN, imem_rdata=32'h1000_0000
//    -> illegal_op=1, instr_valid stays 0, no further imem_req until reset.
//    Macro undefined -> word issued normally, illegal_op=0.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// Fetch/PC sequencer: requests instruction words, issues them downstream and selects the next PC.
// Optional macro FETCH_BADOP_EN: undefined opcodes set sticky illegal_op and halt fetching.
module instr_fetch_seq #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_accept,
  output logic [31:0]     instr,
  output logic [3:0]      opcode,
  output logic [5:0]      rd,
  output logic [5:0]      rs,
  output logic [5:0]      rt,
  output logic [PC_W-1:0] pc_out,
  input  logic            ctl_valid,
  input  logic            jump,
  input  logic            jumpMem,
  input  logic            branchZ,
  input  logic            branchN,
  input  logic            flag_z,
  input  logic            flag_n,
  input  logic [PC_W-1:0] target_addr,
  output logic            illegal_op
);

`ifdef FETCH_BADOP_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_RESOLVE, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_RESOLVE} state_t;
`endif

  state_t          r_state;
  state_t          w_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc_out;
  logic            w_capture;
  logic            w_take;
  logic            w_bad;

  assign w_take = jump | jumpMem | (branchZ & flag_z) | (branchN & flag_n);

`ifdef FETCH_BADOP_EN
  logic r_illegal;
  logic w_set_bad;
  assign w_bad      = (r_instr[31:28] inside {4'b0001, 4'b0010, 4'b1001, 4'b1100, 4'b1101});
  assign illegal_op = r_illegal;
`else
  assign w_bad      = 1'b0;
  assign illegal_op = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_pc_next = r_pc;
    w_capture = 1'b0;
`ifdef FETCH_BADOP_EN
    w_set_bad = 1'b0;
`endif
    case (r_state)
      S_IDLE:  w_next = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          w_capture = 1'b1;
          w_next    = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef FETCH_BADOP_EN
        if (w_bad) begin
          w_set_bad = 1'b1;
          w_next    = S_HALT;
        end else if (instr_accept) begin
          w_next = S_RESOLVE;
        end
`else
        if (instr_accept) w_next = S_RESOLVE;
`endif
      end
      S_RESOLVE: begin
        if (ctl_valid) begin
          w_pc_next = w_take ? target_addr : r_pc + PC_W'(1);
          w_next    = S_FETCH;
        end
      end
`ifdef FETCH_BADOP_EN
      S_HALT:  w_next = S_HALT;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_pc_out <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      if (w_capture) begin
        r_instr  <= imem_rdata;
        r_pc_out <= r_pc;
      end
    end
  end

`ifdef FETCH_BADOP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_illegal <= 1'b0;
    else if (w_set_bad) r_illegal <= 1'b1;
  end
`endif

  // Request and valid decode straight from the state register; fields slice the held word.
  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == S_ISSUE) & ~w_bad;
  assign instr       = r_instr;
  assign opcode      = r_instr[31:28];
  assign rd          = r_instr[27:22];
  assign rs          = r_instr[21:16];
  assign rt          = r_instr[15:10];
  assign pc_out      = r_pc_out;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Randomized scoreboard bench for instr_fetch_seq against a transaction-level PC model.
module tb_instr_fetch_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_accept;
  logic [31:0] instr;
  logic [3:0]  opcode;
  logic [5:0]  rd, rs, rt;
  logic [7:0]  pc_out;
  logic        ctl_valid, jump, jumpMem, branchZ, branchN, flag_z, flag_n;
  logic [7:0]  target_addr;
  logic        illegal_op;

  instr_fetch_seq #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_accept(instr_accept), .instr(instr),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .pc_out(pc_out),
    .ctl_valid(ctl_valid), .jump(jump), .jumpMem(jumpMem), .branchZ(branchZ), .branchN(branchN),
    .flag_z(flag_z), .flag_n(flag_n), .target_addr(target_addr), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [7:0]  pc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_popped = 0;
  int         n_res    = 0;
  logic [7:0] exp_pc;
  bit         in_resolve;
  bit         l_req, l_valid;
  int         k_ready, k_accept, k_ctl;
  bit         k_fixed, f_jump, f_bz, f_fz, f_word_en;
  logic [7:0] f_tgt;
  logic [31:0] f_word;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    w = $urandom;
`ifdef FETCH_BADOP_EN
    while (w[31:28] inside {4'b0001, 4'b0010, 4'b1001, 4'b1100, 4'b1101}) w = $urandom;
`endif
    return w;
  endfunction

  // One cycle: observe outputs after the edge, then drive this cycle's inputs.
  task automatic step();
    bit take;
    @(posedge clk); #1;
    l_req   = imem_req;
    l_valid = instr_valid;
    imem_ready   = 1'b0;
    instr_accept = 1'b0;
    jump    = ($urandom_range(0, 9) == 0);
    jumpMem = ($urandom_range(0, 9) == 0);
    branchZ = ($urandom_range(0, 3) == 0);
    branchN = ($urandom_range(0, 3) == 0);
    flag_z  = 1'($urandom);
    flag_n  = 1'($urandom);
    target_addr = 8'($urandom);
    if (k_fixed) begin
      jump = f_jump; jumpMem = 1'b0; branchN = 1'b0;
      branchZ = f_bz; flag_z = f_fz; target_addr = f_tgt;
    end
    if (l_req) begin
      chk("imem_addr", 32'(imem_addr), 32'(exp_pc));
      if ($urandom_range(0, 99) < k_ready) begin
        imem_ready = 1'b1;
        imem_rdata = f_word_en ? f_word : gen_word();
        f_word_en  = 1'b0;
`ifdef FETCH_BADOP_EN
        if (!(imem_rdata[31:28] inside {4'b0001, 4'b0010, 4'b1001, 4'b1100, 4'b1101}))
`endif
          sb_q.push_back('{w: imem_rdata, pc: exp_pc});
      end else begin
        imem_rdata = $urandom;
      end
    end else begin
      imem_rdata = $urandom;
    end
    if (l_valid) instr_accept = ($urandom_range(0, 99) < k_accept);
    else         instr_accept = 1'($urandom);
    ctl_valid = ($urandom_range(0, 99) < k_ctl);
    if (in_resolve && ctl_valid) begin
      take   = jump | jumpMem | (branchZ & flag_z) | (branchN & flag_n);
      exp_pc = take ? target_addr : exp_pc + 8'd1;
      in_resolve = 1'b0;
      n_res++;
    end
    if (l_valid && instr_accept) in_resolve = 1'b1;
  endtask

  task automatic run_resolves(int n, int budget);
    int start;
    start = n_res;
    for (int i = 0; i < budget && (n_res - start) < n; i++) step();
    if ((n_res - start) < n) chk("resolve_timeout", 32'(n_res - start), 32'(n));
  endtask

  task automatic wait_req(int budget);
    l_req = 1'b0;
    for (int i = 0; i < budget && !l_req; i++) step();
    if (!l_req) chk("req_timeout", 32'(l_req), 32'd1);
  endtask

  task automatic set_fixed(bit j, bit bz, bit fz, logic [7:0] tgt);
    k_fixed = 1'b1; f_jump = j; f_bz = bz; f_fz = fz; f_tgt = tgt;
  endtask

  task automatic reset_model();
    exp_pc = 8'h00;
    in_resolve = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 32'(instr_valid), 32'd0);
        end else if (instr_accept) begin
          e = sb_q.pop_front();
          n_popped++;
          chk("instr",  instr,            e.w);
          chk("opcode", 32'(opcode),      32'(e.w[31:28]));
          chk("rd",     32'(rd),          32'(e.w[27:22]));
          chk("rs",     32'(rs),          32'(e.w[21:16]));
          chk("rt",     32'(rt),          32'(e.w[15:10]));
          chk("pc_out", 32'(pc_out),      32'(e.pc));
          chk("illegal_op_clear", 32'(illegal_op), 32'd0);
        end
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0;
    imem_ready = 1'b0; imem_rdata = '0; instr_accept = 1'b0; ctl_valid = 1'b0;
    jump = 1'b0; jumpMem = 1'b0; branchZ = 1'b0; branchN = 1'b0;
    flag_z = 1'b0; flag_n = 1'b0; target_addr = '0;
    f_word_en = 1'b0; f_word = '0;
    reset_model();
    repeat (3) @(negedge clk);
    chk("rst_req",     32'(imem_req),    32'd0);
    chk("rst_valid",   32'(instr_valid), 32'd0);
    chk("rst_addr",    32'(imem_addr),   32'd0);
    chk("rst_instr",   instr,            32'd0);
    chk("rst_pc_out",  32'(pc_out),      32'd0);
    chk("rst_illegal", 32'(illegal_op),  32'd0);
    rst_n = 1'b1;

    // Always-ready handshakes, no redirect: three-cycle cadence.
    k_ready = 100; k_accept = 100; k_ctl = 100;
    set_fixed(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("req_cadence",   32'(l_req),   32'(i % 3 == 0));
      chk("valid_cadence", 32'(l_valid), 32'(i % 3 == 1));
    end

    // Branch on zero taken, then not taken.
    set_fixed(1'b0, 1'b1, 1'b1, 8'h40);
    run_resolves(1, 20); wait_req(20);
    chk("branchz_taken", 32'(imem_addr), 32'h40);
    set_fixed(1'b0, 1'b1, 1'b0, 8'h40);
    run_resolves(1, 20); wait_req(20);
    chk("branchz_not_taken", 32'(imem_addr), 32'h41);

    // PC wrap from 0xFF.
    set_fixed(1'b1, 1'b0, 1'b0, 8'hFF);
    run_resolves(1, 20); wait_req(20);
    chk("jump_ff", 32'(imem_addr), 32'hFF);
    set_fixed(1'b0, 1'b0, 1'b0, 8'h00);
    run_resolves(1, 20); wait_req(20);
    chk("pc_wrap", 32'(imem_addr), 32'h00);

    // Memory stalls four cycles at pc=5.
    set_fixed(1'b1, 1'b0, 1'b0, 8'h05);
    run_resolves(1, 20);
    k_ready = 0;
    wait_req(20);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_req",  32'(l_req),     32'd1);
      chk("stall_addr", 32'(imem_addr), 32'h05);
    end
    k_ready = 100;
    step();
    step();
    chk("issue_after_ready", 32'(l_valid), 32'd1);

    // Randomized traffic.
    k_fixed = 1'b0; k_ready = 60; k_accept = 60; k_ctl = 50;
    repeat (2000) step();

    // Asynchronous reset in the middle of FETCH with ready high.
    k_ready = 0;
    wait_req(100);
    #2;
    imem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req",   32'(imem_req),    32'd0);
    chk("async_rst_addr",  32'(imem_addr),   32'd0);
    chk("async_rst_valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_req",   32'(imem_req),    32'd0);
    chk("rst_hold_valid", 32'(instr_valid), 32'd0);
    chk("sb_empty_at_reset", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    reset_model();
    imem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    k_ready = 60;
    repeat (1000) step();

    // Opcode 0001 word.
    k_ready = 100; k_accept = 100; k_ctl = 100;
    wait_req(100);
    f_word = 32'h1000_0000; f_word_en = 1'b1;
    run_resolves(0, 1);
`ifdef FETCH_BADOP_EN
    // f_word_en consumed only when a request is accepted; wait for that.
    for (int i = 0; i < 20 && f_word_en; i++) step();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_illegal", 32'(illegal_op),  32'd1);
      chk("halt_valid",   32'(l_valid),     32'd0);
      chk("halt_req",     32'(l_req),       32'd0);
    end
`else
    run_resolves(2, 40);
    chk("badop_issued", 32'(sb_q.size() <= 1), 32'd1);
`endif

    chk("issued_count", 32'(n_popped >= 100), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
